// File: rtl/uart_rx_fifo_if.sv
// Read-path and status bundle between the UART receive FIFO and the APB slave.
// The slave modport is the receiver side; the master modport is the APB register block.
interface uart_rx_fifo_if #(
    parameter int unsigned AW = 3
);
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          busy;
    logic          frame_err;
    logic          overrun;

    modport master (
        output rd_en, clr_err,
        input  rd_data, empty, full, count, busy, frame_err, overrun
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, empty, full, count, busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Reports FIFO level plus sticky frame-error and overrun flags.
module uart_rx_fifo #(
    parameter int unsigned DIV = 16,
    parameter int unsigned AW  = 3
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          rx_in,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned DEPTH     = 1 << AW;
    localparam int unsigned CW        = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Line synchronizer; the third flop holds the previous synchronized value for edge detect
    logic rx_meta, rxs, rxs_d;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            stop_ok, stop_bad;
    logic            expire;

    assign expire = (cnt_q == '0);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Receiver next state: sample points fall where the bit counter reaches zero
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        if (state_q != IDLE && !expire) begin
            cnt_d = cnt_q - CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (expire) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = BIT_LOAD;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = BIT_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    state_d  = IDLE;
                    stop_ok  = rxs;
                    stop_bad = !rxs;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, full_q, busy_q, ferr_q, ovr_q;
    logic          pop, push, drop;

    // A pop in the same cycle frees the slot, so a stop on a full FIFO still lands
    assign pop  = bus.rd_en && !empty_q;
    assign push = stop_ok && (!full_q || pop);
    assign drop = stop_ok && full_q && !pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == (AW+1)'(DEPTH));
            busy_q  <= (state_d != IDLE);
            ferr_q  <= stop_bad || (ferr_q && !bus.clr_err);
            ovr_q   <= drop || (ovr_q && !bus.clr_err);
        end
    end

    // Storage is not reset; empty_q masks stale contents on rd_data
    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr] <= shift_q;
    end

    assign bus.rd_data   = empty_q ? 8'h00 : mem[rd_ptr];
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames are driven on rx_in and the
// read path is compared against a queue-based model of received bytes and flags.
module tb_uart_rx_fifo;
    localparam int unsigned DIV   = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
    // rx_in driven low at negedge N0: two synchronizer edges plus the detect edge put T0 at N0+2.5 cycles,
    // so the stop sample T0+152 lies between negedge 154 and negedge 155.
    localparam int unsigned STOP_NEG = 154;

    logic clk = 1'b0;
    logic rst;
    logic rx_in;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    logic [7:0] q[$];
    logic       exp_ferr;
    logic       exp_ovr;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.AW(AW)) bus ();

    uart_rx_fifo #(.DIV(DIV), .AW(AW)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .rx_in  (rx_in),
        .bus    (bus)
    );

    // Serial driver: start, 8 data bits LSB first, stop, then idle-high gap
    task automatic drive_frame(input logic [7:0] b, input logic stop_val, input int gap);
        rx_in = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx_in = stop_val;
        repeat (DIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic ok);
        if (!ok)                    exp_ferr = 1'b1;
        else if (q.size() == DEPTH) exp_ovr  = 1'b1;
        else                        q.push_back(b);
    endfunction

    task automatic pulse_pop();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_in = 1'b1; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
        q.delete(); exp_ferr = 1'b0; exp_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_cnt++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.empty); else pass_cnt++;
        chk_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.full); else pass_cnt++;
        chk_cnt++; if (bus.count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); else pass_cnt++;
        chk_cnt++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0)
            $display("FAIL reset_flags got=%b%b exp=00", bus.frame_err, bus.overrun); else pass_cnt++;
    endtask

    task automatic test_single();
        fork
            drive_frame(8'hD4, 1'b1, 4);
            begin
                repeat (2) @(negedge clk);
                chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_busy_pre got=%b exp=0", bus.busy); else pass_cnt++;
                @(negedge clk);
                chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy_rise got=%b exp=1", bus.busy); else pass_cnt++;
                repeat (STOP_NEG - 3) @(negedge clk);
                chk_cnt++; if (bus.count !== 4'd0 || bus.busy !== 1'b1)
                    $display("FAIL single_pre_stop got count=%0d busy=%b exp 0/1", bus.count, bus.busy); else pass_cnt++;
                @(negedge clk);
                chk_cnt++; if (bus.count !== 4'd1) $display("FAIL single_count got=%0d exp=1", bus.count); else pass_cnt++;
                chk_cnt++; if (bus.rd_data !== 8'hD4) $display("FAIL single_rd_data got=%h exp=d4", bus.rd_data); else pass_cnt++;
                chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_busy_fall got=%b exp=0", bus.busy); else pass_cnt++;
            end
        join
        model_frame(8'hD4, 1'b1);
        pulse_pop();
        chk_cnt++; if (bus.empty !== 1'b1 || bus.count !== 4'd0)
            $display("FAIL single_pop got empty=%b count=%0d exp 1/0", bus.empty, bus.count); else pass_cnt++;
    endtask

    task automatic test_fill_overrun();
        for (int v = 1; v <= 9; v++) begin
            drive_frame(8'(v), 1'b1, 4);
            model_frame(8'(v), 1'b1);
            if (v == 7) begin
                chk_cnt++; if (bus.full !== 1'b0) $display("FAIL fill_full7 got=%b exp=0", bus.full); else pass_cnt++;
            end
            if (v == 8) begin
                chk_cnt++; if (bus.full !== 1'b1 || bus.count !== 4'd8)
                    $display("FAIL fill_full8 got full=%b count=%0d exp 1/8", bus.full, bus.count); else pass_cnt++;
                chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL fill_ovr8 got=%b exp=0", bus.overrun); else pass_cnt++;
            end
        end
        chk_cnt++; if (bus.overrun !== 1'b1 || bus.count !== 4'd8)
            $display("FAIL fill_overrun got ovr=%b count=%0d exp 1/8", bus.overrun, bus.count); else pass_cnt++;
        for (int i = 1; i <= 8; i++) begin
            chk_cnt++; if (bus.rd_data !== 8'(i)) $display("FAIL drain_%0d got=%h exp=%h", i, bus.rd_data, 8'(i)); else pass_cnt++;
            pulse_pop();
        end
        chk_cnt++; if (bus.empty !== 1'b1 || bus.count !== 4'd0)
            $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", bus.empty, bus.count); else pass_cnt++;
        pulse_pop();
        chk_cnt++; if (bus.count !== 4'd0) $display("FAIL pop_empty_count got=%0d exp=0", bus.count); else pass_cnt++;
        pulse_clr();
        chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL clr_overrun got=%b exp=0", bus.overrun); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        drive_frame(8'h11, 1'b1, 4);
        model_frame(8'h11, 1'b1);
        // Clear pulse coincident with the failing stop sample must not win
        fork
            drive_frame(8'h55, 1'b0, 4);
            begin
                repeat (STOP_NEG) @(negedge clk);
                bus.clr_err = 1'b1;
                @(negedge clk);
                bus.clr_err = 1'b0;
            end
        join
        model_frame(8'h55, 1'b0);
        chk_cnt++; if (bus.frame_err !== 1'b1) $display("FAIL ferr_set got=%b exp=1", bus.frame_err); else pass_cnt++;
        chk_cnt++; if (bus.count !== 4'(q.size())) $display("FAIL ferr_count got=%0d exp=%0d", bus.count, q.size()); else pass_cnt++;
        chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL ferr_ovr got=%b exp=0", bus.overrun); else pass_cnt++;
        pulse_clr();
        chk_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL ferr_clr got=%b exp=0", bus.frame_err); else pass_cnt++;
    endtask

    task automatic test_glitch_reset();
        int n;
        n = q.size();
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        chk_cnt++; if (bus.busy !== 1'b0 || bus.count !== 4'(n))
            $display("FAIL glitch got busy=%b count=%0d exp 0/%0d", bus.busy, bus.count, n); else pass_cnt++;
        chk_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL glitch_ferr got=%b exp=0", bus.frame_err); else pass_cnt++;
        drive_frame(8'h3C, 1'b0, 4);
        fork
            drive_frame(8'hA5, 1'b1, 4);
            begin
                repeat (80) @(negedge clk);
                rst = 1'b1;
                repeat (5) @(negedge clk);
                chk_cnt++; if (bus.busy !== 1'b0 || bus.empty !== 1'b1 || bus.full !== 1'b0)
                    $display("FAIL preset_state got busy=%b empty=%b full=%b", bus.busy, bus.empty, bus.full); else pass_cnt++;
                chk_cnt++; if (bus.count !== 4'd0 || bus.rd_data !== 8'h00)
                    $display("FAIL preset_data got count=%0d rd_data=%h exp 0/00", bus.count, bus.rd_data); else pass_cnt++;
                chk_cnt++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0)
                    $display("FAIL preset_flags got=%b%b exp=00", bus.frame_err, bus.overrun); else pass_cnt++;
            end
        join
        rst = 1'b0;
        q.delete(); exp_ferr = 1'b0; exp_ovr = 1'b0;
        repeat (30) @(negedge clk);
        chk_cnt++; if (bus.empty !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL preset_after got empty=%b busy=%b exp 1/0", bus.empty, bus.busy); else pass_cnt++;
    endtask

    task automatic test_full_pop_at_stop();
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            drive_frame(b, 1'b1, 3);
            model_frame(b, 1'b1);
        end
        b = 8'($urandom);
        fork
            drive_frame(b, 1'b1, 4);
            begin
                repeat (STOP_NEG) @(negedge clk);
                bus.rd_en = 1'b1;
                @(negedge clk);
                bus.rd_en = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(b);
        chk_cnt++; if (bus.count !== 4'd8 || bus.full !== 1'b1)
            $display("FAIL fullpop_count got=%0d full=%b exp 8/1", bus.count, bus.full); else pass_cnt++;
        chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL fullpop_ovr got=%b exp=0", bus.overrun); else pass_cnt++;
        while (q.size() > 0) begin
            chk_cnt++; if (bus.rd_data !== q[0]) $display("FAIL fullpop_drain got=%h exp=%h", bus.rd_data, q[0]); else pass_cnt++;
            pulse_pop();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            drive_frame(b, 1'b1, (i == 2) ? 4 : 0);
            model_frame(b, 1'b1);
        end
        chk_cnt++; if (bus.count !== 4'(q.size())) $display("FAIL b2b_count got=%0d exp=%0d", bus.count, q.size()); else pass_cnt++;
        while (q.size() > 0) begin
            chk_cnt++; if (bus.rd_data !== q[0]) $display("FAIL b2b_data got=%h exp=%h", bus.rd_data, q[0]); else pass_cnt++;
            pulse_pop();
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       ok;
        logic [7:0] head;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 4) == 0) pulse_clr();
            for (int p = $urandom_range(0, 3); p > 0; p--) begin
                head = (q.size() > 0) ? q[0] : 8'h00;
                chk_cnt++; if (bus.rd_data !== head) $display("FAIL rand_head got=%h exp=%h", bus.rd_data, head); else pass_cnt++;
                pulse_pop();
            end
            b  = 8'($urandom);
            ok = ($urandom_range(0, 6) != 0);
            drive_frame(b, ok, $urandom_range(1, 6));
            model_frame(b, ok);
            head = (q.size() > 0) ? q[0] : 8'h00;
            chk_cnt++; if (bus.count !== 4'(q.size()) || bus.rd_data !== head)
                $display("FAIL rand_level got count=%0d head=%h exp %0d/%h", bus.count, bus.rd_data, q.size(), head); else pass_cnt++;
            chk_cnt++; if (bus.full !== (q.size() == DEPTH) || bus.empty !== (q.size() == 0))
                $display("FAIL rand_fe got full=%b empty=%b size=%0d", bus.full, bus.empty, q.size()); else pass_cnt++;
            chk_cnt++; if (bus.frame_err !== exp_ferr || bus.overrun !== exp_ovr)
                $display("FAIL rand_flags got=%b%b exp=%b%b", bus.frame_err, bus.overrun, exp_ferr, exp_ovr); else pass_cnt++;
        end
        while (q.size() > 0) begin
            chk_cnt++; if (bus.rd_data !== q[0]) $display("FAIL rand_drain got=%h exp=%h", bus.rd_data, q[0]); else pass_cnt++;
            pulse_pop();
        end
    endtask

    initial begin
        rst = 1'b1; rx_in = 1'b1; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_overrun();
        test_frame_err();
        test_glitch_reset();
        test_full_pop_at_stop();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
